// File: rtl/ex_result_buffer_if.sv
// Handshake bundle between execute (push side) and the memory stage (pop side)
// of ex_result_buffer.
interface ex_result_buffer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic        in_zero;
    logic        in_negative;
    logic        in_overflow;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic [31:0] in_pc;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_negative;
    logic        out_overflow;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic [31:0] out_pc;
    logic        out_trap;

    // The buffer itself.
    modport slave (
        input  in_valid, in_result, in_zero, in_negative, in_overflow,
               in_rd, in_wen, in_pc, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_negative,
               out_overflow, out_rd, out_wen, out_pc, out_trap
    );

    // Execute and memory stage together, as seen from outside the buffer.
    modport master (
        output in_valid, in_result, in_zero, in_negative, in_overflow,
               in_rd, in_wen, in_pc, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_negative,
               out_overflow, out_rd, out_wen, out_pc, out_trap
    );
endinterface

// File: rtl/ex_result_buffer.sv
// Elastic FIFO between the ALU and the memory stage, with a synchronous flush.
// Optional overflow trap tagging is enabled by defining EX_RESULT_BUFFER_OVF_TRAP_EN.
module ex_result_buffer #(
    parameter int DEPTH = 2
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    ex_result_buffer_if.slave        bus,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        negative;
        logic        overflow;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] pc;
`ifdef EX_RESULT_BUFFER_OVF_TRAP_EN
        logic        trap;
`endif
    } entry_t;

    entry_t        mem_q [DEPTH];
    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   count_q, count_d;

    logic   push, pop;
    entry_t wr_entry;
    entry_t head;

    // in_ready comes from registered occupancy only, so out_ready never reaches execute.
    assign bus.in_ready  = (count_q != FULL_CNT);
    assign bus.out_valid = (count_q != '0);
    assign count         = count_q;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        push     = bus.in_valid & bus.in_ready & ~flush;
        pop      = bus.out_valid & bus.out_ready & ~flush;
        wp_d     = wp_q;
        rp_d     = rp_q;
        count_d  = count_q;

        wr_entry          = '0;
        wr_entry.result   = bus.in_result;
        wr_entry.zero     = bus.in_zero;
        wr_entry.negative = bus.in_negative;
        wr_entry.overflow = bus.in_overflow;
        wr_entry.rd       = bus.in_rd;
        wr_entry.wen      = bus.in_wen;
        wr_entry.pc       = bus.in_pc;
`ifdef EX_RESULT_BUFFER_OVF_TRAP_EN
        wr_entry.trap     = bus.in_overflow & bus.in_wen;
`endif

        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + 1'b1;
            if (pop)  rp_d = rp_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately reset as well, so no stale payload survives a reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wp_q] <= wr_entry;
        end
    end

    // An empty buffer presents all-zero data rather than whatever sits at rp.
    assign head = bus.out_valid ? mem_q[rp_q] : '0;

    assign bus.out_result   = head.result;
    assign bus.out_zero     = head.zero;
    assign bus.out_negative = head.negative;
    assign bus.out_overflow = head.overflow;
    assign bus.out_rd       = head.rd;
    assign bus.out_pc       = head.pc;

`ifdef EX_RESULT_BUFFER_OVF_TRAP_EN
    // A trapping write is suppressed here so it never reaches the register file.
    assign bus.out_trap = head.trap;
    assign bus.out_wen  = head.wen & ~head.trap;
`else
    assign bus.out_trap = 1'b0;
    assign bus.out_wen  = head.wen;
`endif

endmodule

// File: tb/tb_ex_result_buffer.sv
// Scoreboard testbench for ex_result_buffer: expected entries are queued at push
// and compared field by field when the memory stage pops them.
module tb_ex_result_buffer;
    localparam int DEPTH = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic [CW-1:0] count;

    ex_result_buffer_if bus ();

    ex_result_buffer #(.DEPTH(DEPTH)) dut (
        .CLK   (clk),
        .nRST  (rst_n),
        .flush (flush),
        .bus   (bus),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        negative;
        logic        overflow;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] pc;
        logic        trap;
    } exp_t;

    exp_t sb[$];
    int   mcount = 0;
    int   errors = 0;
    int   checks = 0;

    task automatic drive(input logic v, input logic [31:0] res, input logic [4:0] rd,
                         input logic wen, input logic ovf, input logic rdy, input logic fl);
        bus.in_valid    = v;
        bus.in_result   = res;
        bus.in_zero     = (res == 32'h0);
        bus.in_negative = res[31];
        bus.in_overflow = ovf;
        bus.in_rd       = rd;
        bus.in_wen      = wen;
        bus.in_pc       = 32'h0000_1000 + {res[29:0], 2'b00};
        bus.out_ready   = rdy;
        flush           = fl;
    endtask

    // One clock: predict push/pop from the bench model, score any pop, advance to the next negedge.
    task automatic tick();
        logic push, pop;
        exp_t e, h;
        logic exp_wen;
        push = bus.in_valid && (mcount != DEPTH) && !flush;
        pop  = (mcount != 0) && bus.out_ready && !flush;
        if (pop) begin
            h = sb.pop_front();
`ifdef EX_RESULT_BUFFER_OVF_TRAP_EN
            exp_wen = h.wen & ~h.trap;
`else
            exp_wen = h.wen;
`endif
            checks++;
            if ({bus.out_valid, bus.out_result, bus.out_zero, bus.out_negative, bus.out_overflow,
                 bus.out_rd, bus.out_wen, bus.out_pc, bus.out_trap} !==
                {1'b1, h.result, h.zero, h.negative, h.overflow, h.rd, exp_wen, h.pc, h.trap}) begin
                errors++;
                $display("FAIL pop_entry: got result=%h rd=%0d wen=%b pc=%h trap=%b valid=%b, expected result=%h rd=%0d wen=%b pc=%h trap=%b",
                         bus.out_result, bus.out_rd, bus.out_wen, bus.out_pc, bus.out_trap, bus.out_valid,
                         h.result, h.rd, exp_wen, h.pc, h.trap);
            end
        end
        if (push) begin
            e.result   = bus.in_result;
            e.zero     = bus.in_zero;
            e.negative = bus.in_negative;
            e.overflow = bus.in_overflow;
            e.rd       = bus.in_rd;
            e.wen      = bus.in_wen;
            e.pc       = bus.in_pc;
`ifdef EX_RESULT_BUFFER_OVF_TRAP_EN
            e.trap     = bus.in_overflow & bus.in_wen;
`else
            e.trap     = 1'b0;
`endif
            sb.push_back(e);
        end
        if (flush) begin
            sb.delete();
            mcount = 0;
        end else begin
            mcount = mcount + (push ? 1 : 0) - (pop ? 1 : 0);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_idle();
        checks++;
        if ({bus.out_valid, bus.in_ready, count, bus.out_result, bus.out_trap, bus.out_wen} !==
            {1'b0, 1'b1, CW'(0), 32'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle: valid=%b ready=%b count=%0d result=%h trap=%b, expected 0 1 0 0 0",
                     bus.out_valid, bus.in_ready, count, bus.out_result, bus.out_trap);
        end
    endtask

    task automatic test_single();
        drive(1, 32'h0000_0005, 5'd3, 1, 0, 0, 0);
        tick();
        checks++;
        if ({bus.out_valid, bus.out_result, bus.out_rd, count} !== {1'b1, 32'h5, 5'd3, CW'(1)}) begin
            errors++;
            $display("FAIL single_visible: valid=%b result=%h rd=%0d count=%0d, expected 1 5 3 1",
                     bus.out_valid, bus.out_result, bus.out_rd, count);
        end
        drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
        tick();
        checks++;
        if ({bus.out_valid, count, bus.out_result} !== {1'b0, CW'(0), 32'h0}) begin
            errors++;
            $display("FAIL single_drained: valid=%b count=%0d result=%h, expected 0 0 0",
                     bus.out_valid, count, bus.out_result);
        end
    endtask

    task automatic test_back_pressure();
        drive(1, 32'h11, 5'd1, 1, 0, 0, 0);
        tick();
        drive(1, 32'h22, 5'd2, 1, 0, 0, 0);
        tick();
        checks++;
        if ({count, bus.in_ready} !== {CW'(2), 1'b0}) begin
            errors++;
            $display("FAIL bp_full: count=%0d in_ready=%b, expected 2 0", count, bus.in_ready);
        end
        drive(1, 32'h33, 5'd3, 1, 0, 0, 0);
        tick();
        checks++;
        if ({count, bus.out_result} !== {CW'(2), 32'h11}) begin
            errors++;
            $display("FAIL bp_refused: count=%0d head=%h, expected 2 00000011", count, bus.out_result);
        end
        drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
        tick();
        checks++;
        if (bus.out_result !== 32'h11) begin
            errors++;
            $display("FAIL bp_stable: head=%h, expected 00000011", bus.out_result);
        end
        drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
        tick();
        checks++;
        if ({count, bus.in_ready} !== {CW'(1), 1'b1}) begin
            errors++;
            $display("FAIL bp_ready_back: count=%0d in_ready=%b, expected 1 1", count, bus.in_ready);
        end
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 1; i <= 10; i++) begin
            drive(1, 32'(i), 5'(i), 1, 0, 1, 0);
            tick();
            checks++;
            if (count !== CW'(1)) begin
                errors++;
                $display("FAIL stream_count: cycle %0d count=%0d, expected 1", i, count);
            end
        end
        drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
        tick();
        checks++;
        if (count !== CW'(0)) begin
            errors++;
            $display("FAIL stream_drain: count=%0d, expected 0", count);
        end
    endtask

    task automatic test_flush();
        drive(1, 32'h44, 5'd4, 1, 0, 0, 0);
        tick();
        drive(1, 32'h55, 5'd5, 1, 0, 0, 0);
        tick();
        drive(1, 32'h99, 5'd9, 1, 0, 1, 1);
        tick();
        checks++;
        if ({count, bus.out_valid, bus.out_result} !== {CW'(0), 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL flush_clear: count=%0d valid=%b result=%h, expected 0 0 0",
                     count, bus.out_valid, bus.out_result);
        end
        drive(1, 32'h77, 5'd7, 1, 0, 0, 0);
        tick();
        checks++;
        if ({count, bus.out_result} !== {CW'(1), 32'h77}) begin
            errors++;
            $display("FAIL flush_after: count=%0d head=%h, expected 1 00000077", count, bus.out_result);
        end
        drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_trap();
        logic exp_trap, exp_wen;
`ifdef EX_RESULT_BUFFER_OVF_TRAP_EN
        exp_trap = 1'b1;
        exp_wen  = 1'b0;
`else
        exp_trap = 1'b0;
        exp_wen  = 1'b1;
`endif
        drive(1, 32'h8000_0000, 5'd6, 1, 1, 0, 0);
        tick();
        checks++;
        if ({bus.out_trap, bus.out_wen, bus.out_overflow} !== {exp_trap, exp_wen, 1'b1}) begin
            errors++;
            $display("FAIL trap_flags: trap=%b wen=%b ovf=%b, expected %b %b 1",
                     bus.out_trap, bus.out_wen, bus.out_overflow, exp_trap, exp_wen);
        end
        drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
        tick();
    endtask

    task automatic test_reset_midstream();
        drive(1, 32'hA1, 5'd10, 1, 0, 0, 0);
        tick();
        drive(1, 32'hA2, 5'd11, 1, 0, 0, 0);
        tick();
        checks++;
        if (count !== CW'(2)) begin
            errors++;
            $display("FAIL rst_setup: count=%0d, expected 2", count);
        end
        drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        sb.delete();
        mcount = 0;
        checks++;
        if ({bus.out_valid, bus.in_ready, count, bus.out_result} !== {1'b0, 1'b1, CW'(0), 32'h0}) begin
            errors++;
            $display("FAIL rst_async: valid=%b ready=%b count=%0d result=%h, expected 0 1 0 0",
                     bus.out_valid, bus.in_ready, count, bus.out_result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'hB0, 5'd12, 1, 0, 0, 0);
        tick();
        checks++;
        if ({count, bus.out_result} !== {CW'(1), 32'hB0}) begin
            errors++;
            $display("FAIL rst_first_push: count=%0d head=%h, expected 1 000000b0", count, bus.out_result);
        end
        drive(0, 32'h0, 5'd0, 0, 0, 1, 0);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 32'h0, 5'd0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        test_reset_idle();
        rst_n = 1'b1;
        test_single();
        test_back_pressure();
        test_streaming();
        test_flush();
        test_trap();
        test_reset_midstream();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_result_buffer.md
# ex_result_buffer

Elastic buffer between the ALU and the memory stage. It captures each ALU result together with its flags and writeback control, and presents the entries in order to the memory stage over a valid/ready handshake. Downstream back-pressure therefore stalls the execute stage cleanly, with no combinational path from the memory stage's ready signal back into execute. A synchronous flush discards all in-flight entries on branch mispredict.

## Interface
Parameters:
- DEPTH, 2, number of entries; a power of two, 2 or greater.

Ports:
- CLK  in  1  rising-edge clock.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards all entries.
- in_valid  in  1  execute presents an entry.
- in_ready  out  1  buffer can accept an entry.
- in_result  in  32  ALU port_out.
- in_zero, in_negative, in_overflow  in  1 each  ALU flags.
- in_rd  in  5  destination register.
- in_wen  in  1  register write enable.
- in_pc  in  32  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage accepts the head entry.
- out_result  out  32, out_zero/out_negative/out_overflow  out  1 each, out_rd  out  5, out_wen  out  1, out_pc  out  32: fields of the head entry.
- out_trap  out  1  head entry raised an overflow trap.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Storage is a circular array of DEPTH entries, indexed by a write pointer wp and a read pointer rp, each $clog2(DEPTH) bits and wrapping naturally.
- Push: in_valid & in_ready & !flush. The entry is written at wp, and wp increments.
- Pop: out_valid & out_ready & !flush. rp increments.
- On a simultaneous push and pop, count is unchanged and both pointers advance.
- in_ready = (count != DEPTH). It is a function of registered state only and never depends on out_ready.
- out_valid = (count != 0).
- out_* show the entry at rp. When count == 0, all out_* data fields read 0.
- Flush: at the next edge count, wp and rp become 0. A push or pop in the same cycle is ignored, so flush has priority.
- Full case: in_ready = 0, so no push occurs even if a pop happens in the same cycle. in_ready rises one cycle after the pop.
- Entries stay in FIFO order. The stored payload is never modified after the write.

## Timing
- Reset (nRST low, asynchronous): count = 0, wp = rp = 0, storage cleared.
  - Outputs: out_valid = 0, in_ready = 1, all out_* data = 0, out_trap = 0.
- Latency: an entry pushed at edge N appears on out_* with out_valid = 1 after edge N, i.e. in cycle N+1. There is no same-cycle bypass.
- Throughput: one push and one pop per cycle. With out_ready held at 1 the buffer sustains 1 entry per cycle at count = 1.
- out_* remain stable while out_valid = 1 and out_ready = 0.
- Reset asserted mid-operation: all state clears immediately and entries are lost. The first push is accepted at the first edge after nRST deasserts.

## Configuration
- Macro: EX_RESULT_BUFFER_OVF_TRAP_EN.
- Defined:
  - At push, trap bit = in_overflow & in_wen.
  - out_trap presents the head entry's trap bit.
  - out_wen = stored wen & !trap bit, so an overflowing write never reaches the register file.
- Undefined:
  - No trap bit is stored.
  - out_trap is constant 0.
  - out_wen = stored wen.

## Test plan
- Reset: nRST low mid-stream with count = 2 -> out_valid = 0, in_ready = 1, count = 0, out_result = 0 immediately, before any clock edge.
- Single entry: push result 0x0000_0005, rd = 3, wen = 1 at edge N -> out_valid = 1, out_result = 0x5, out_rd = 3 in cycle N+1; pop -> count = 0.
- Back-pressure: out_ready = 0, push A = 0x11, B = 0x22 -> count = 2, in_ready = 0. A third push is refused. Raise out_ready -> A, then B, each held stable until popped.
- Streaming: in_valid = out_ready = 1 for 10 cycles with results 1..10 -> outputs 1..10 in order, count stays at 1, no bubbles.
- Flush: count = 2 with flush and a push in the same cycle -> next cycle count = 0, out_valid = 0, and the pushed entry is absent.
- Trap (macro defined): push in_overflow = 1, wen = 1, result 0x8000_0000 -> out_trap = 1, out_wen = 0. With the macro undefined -> out_trap = 0, out_wen = 1.
